dp_mem_responder: RTL and testbench

Synthesizable dual-port memory responder: the target side of the read/write/resp handshake the DGM pipeline drives on its IF and MEM ports. It replaces the behavioural dual-port memory model in benches and FPGA builds. It adds programmable wait states per port, so pipeline stall logic is exercised at nonzero memory latency. Storage is a flop array shared by both ports.

---
 rtl/dp_mem_pkg.sv | 28 ++
 rtl/dp_mem_port_fsm.sv | 107 ++++++++++
 rtl/dp_mem_responder.sv | 129 ++++++++++++
 tb/tb_dp_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_mem_pkg.sv
// Shared types and helpers for the dual-port memory responder.
package dp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } port_state_t;

    localparam int WORD_W      = 16;
    localparam int MASK_W      = 2;
    localparam int MAX_LATENCY = 15;

    // Byte-lane merge of new data into an existing word.
    function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_word,
                                                     input logic [WORD_W-1:0] data,
                                                     input logic [MASK_W-1:0] mask);
        logic [WORD_W-1:0] result;
        result = old_word;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                result[i*8 +: 8] = data[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dp_mem_port_fsm.sv
// Per-port request FSM: captures the request, counts wait states, handles abort and
// strobes the storage access on the edge that registers the response.
module dp_mem_port_fsm
    import dp_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [MASK_W-1:0] i_wmask,
    input  logic [15:0]       i_address,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_acc_valid,
    output logic              o_acc_write,
    output logic              o_acc_read,
    output logic [15:0]       o_acc_address,
    output logic [WORD_W-1:0] o_acc_wdata,
    output logic [MASK_W-1:0] o_acc_wmask,
    output logic              o_resp,
    output logic              o_err
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    port_state_t       r_state;
    logic [3:0]        r_cnt;
    logic              r_read;
    logic              r_write;
    logic [15:0]       r_address;
    logic [WORD_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_resp;
    logic              r_err;

    logic w_req;
    logic w_fire_idle;
    logic w_fire_wait;
    logic w_use_inputs;

    assign w_req        = i_read | i_write;
    assign w_fire_idle  = (r_state == IDLE) && w_req && (LATENCY == 1);
    assign w_fire_wait  = (r_state == WAIT) && w_req && (r_cnt == 4'd1);
    // With single-cycle latency the access happens on the capture edge itself.
    assign w_use_inputs = (r_state == IDLE);

    assign o_acc_valid   = w_fire_idle | w_fire_wait;
    assign o_acc_write   = o_acc_valid & (w_use_inputs ? i_write : r_write);
    assign o_acc_read    = o_acc_valid & (w_use_inputs ? (i_read & ~i_write)
                                                       : (r_read & ~r_write));
    assign o_acc_address = w_use_inputs ? i_address : r_address;
    assign o_acc_wdata   = w_use_inputs ? i_wdata : r_wdata;
    assign o_acc_wmask   = w_use_inputs ? i_wmask : r_wmask;
    assign o_resp        = r_resp;
    assign o_err         = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= 16'h0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_resp    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_read    <= i_read;
                        r_write   <= i_write;
                        r_address <= i_address;
                        r_wdata   <= i_wdata;
                        r_wmask   <= i_wmask;
                        r_cnt     <= LAT_M1;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                            r_err   <= i_read & i_write;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        r_err   <= r_read & r_write;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dp_mem_responder.sv
// Dual-port memory responder: flop storage shared by two independent wait-state ports,
// with port A winning per byte lane on same-word write collisions.
module dp_mem_responder
    import dp_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY_A   = 2,
    parameter int unsigned LATENCY_B   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic        write_a,
    input  logic [1:0]  wmask_a,
    input  logic [15:0] address_a,
    input  logic [15:0] wdata_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    output logic        err_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic        err_b
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic              w_acc_a, w_wr_a, w_rd_a;
    logic              w_acc_b, w_wr_b, w_rd_b;
    logic [15:0]       w_addr_a, w_addr_b;
    logic [WORD_W-1:0] w_wdata_a, w_wdata_b;
    logic [MASK_W-1:0] w_wmask_a, w_wmask_b;
    logic [IDX_W-1:0]  w_idx_a, w_idx_b;
    logic [WORD_W-1:0] w_base_a, w_new_a, w_new_b;
    logic              w_unused_acc;

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata_a;
    logic [WORD_W-1:0] r_rdata_b;

    dp_mem_port_fsm #(
        .LATENCY (LATENCY_A)
    ) u_port_a (
        .clk           (clk),
        .rst           (rst),
        .i_read        (read_a),
        .i_write       (write_a),
        .i_wmask       (wmask_a),
        .i_address     (address_a),
        .i_wdata       (wdata_a),
        .o_acc_valid   (w_acc_a),
        .o_acc_write   (w_wr_a),
        .o_acc_read    (w_rd_a),
        .o_acc_address (w_addr_a),
        .o_acc_wdata   (w_wdata_a),
        .o_acc_wmask   (w_wmask_a),
        .o_resp        (resp_a),
        .o_err         (err_a)
    );

    dp_mem_port_fsm #(
        .LATENCY (LATENCY_B)
    ) u_port_b (
        .clk           (clk),
        .rst           (rst),
        .i_read        (read_b),
        .i_write       (write_b),
        .i_wmask       (wmask_b),
        .i_address     (address_b),
        .i_wdata       (wdata_b),
        .o_acc_valid   (w_acc_b),
        .o_acc_write   (w_wr_b),
        .o_acc_read    (w_rd_b),
        .o_acc_address (w_addr_b),
        .o_acc_wdata   (w_wdata_b),
        .o_acc_wmask   (w_wmask_b),
        .o_resp        (resp_b),
        .o_err         (err_b)
    );

    // Upper address bits alias; bit 0 is the byte offset.
    assign w_idx_a      = w_addr_a[IDX_W:1];
    assign w_idx_b      = w_addr_b[IDX_W:1];
    assign w_unused_acc = ^{w_acc_a, w_acc_b, w_addr_a[15:IDX_W+1], w_addr_a[0],
                            w_addr_b[15:IDX_W+1], w_addr_b[0]};

    // A merges on top of B's result so lanes only B enables survive a same-word collision.
    assign w_new_b  = merge_word(r_mem[w_idx_b], w_wdata_b, w_wmask_b);
    assign w_base_a = (w_wr_b && (w_idx_b == w_idx_a)) ? w_new_b : r_mem[w_idx_a];
    assign w_new_a  = merge_word(w_base_a, w_wdata_a, w_wmask_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_b) begin
                r_mem[w_idx_b] <= w_new_b;
            end
            if (w_wr_a) begin
                r_mem[w_idx_a] <= w_new_a;
            end
        end
    end

    // Reads sample the pre-write contents of the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (w_rd_a) begin
                r_rdata_a <= r_mem[w_idx_a];
            end
            if (w_rd_b) begin
                r_rdata_b <= r_mem[w_idx_b];
            end
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: directed vector table, collision/abort/reset sequences,
// and a randomized two-port run against a transaction-level memory model.
module tb_dp_mem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_a = 1'b0, write_a = 1'b0, read_b = 1'b0, write_b = 1'b0;
    logic [1:0]  wmask_a = 2'b00, wmask_b = 2'b00;
    logic [15:0] address_a = 16'h0, address_b = 16'h0, wdata_a = 16'h0, wdata_b = 16'h0;
    logic        resp_a, resp_b, err_a, err_b;
    logic [15:0] rdata_a, rdata_b;

    int checks   = 0;
    int failures = 0;

    dp_mem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY_A   (LAT_A),
        .LATENCY_B   (LAT_B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .read_a    (read_a),
        .write_a   (write_a),
        .wmask_a   (wmask_a),
        .address_a (address_a),
        .wdata_a   (wdata_a),
        .resp_a    (resp_a),
        .rdata_a   (rdata_a),
        .err_a     (err_a),
        .read_b    (read_b),
        .write_b   (write_b),
        .wmask_b   (wmask_b),
        .address_b (address_b),
        .wdata_b   (wdata_b),
        .resp_b    (resp_b),
        .rdata_b   (rdata_b),
        .err_b     (err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit rd, input bit wr, input logic [15:0] ad,
                         input logic [15:0] wd, input logic [1:0] mk);
        if (!p) begin
            read_a = rd; write_a = wr; address_a = ad; wdata_a = wd; wmask_a = mk;
        end else begin
            read_b = rd; write_b = wr; address_b = ad; wdata_b = wd; wmask_b = mk;
        end
    endtask

    function automatic logic get_resp(input bit p);
        return p ? resp_b : resp_a;
    endfunction

    function automatic logic get_err(input bit p);
        return p ? err_b : err_a;
    endfunction

    function automatic logic [15:0] get_rdata(input bit p);
        return p ? rdata_b : rdata_a;
    endfunction

    function automatic logic [15:0] model_write(input logic [15:0] old_w,
                                                input logic [15:0] d, input logic [1:0] m);
        logic [15:0] w;
        w = old_w;
        if (m[0]) w[7:0] = d[7:0];
        if (m[1]) w[15:8] = d[15:8];
        return w;
    endfunction

    // Called just after a rising edge; returns just after a later rising edge.
    task automatic txn(input bit p, input bit rd, input bit wr, input logic [15:0] ad,
                       input logic [15:0] wd, input logic [1:0] mk,
                       output logic [15:0] rdata, output logic err, output int lat,
                       output logic resp_after);
        bit got;
        got = 1'b0;
        lat = -1;
        rdata = 'x;
        err = 1'bx;
        drive(p, rd, wr, ad, wd, mk);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (get_resp(p)) begin
                got = 1'b1;
                lat = c;
                rdata = get_rdata(p);
                err = get_err(p);
            end else begin
                @(posedge clk);
            end
        end
        drive(p, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(posedge clk);
        @(negedge clk);
        resp_after = get_resp(p);
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[10];
    logic [15:0] mdl[256];
    logic [15:0] t_rdata;
    logic        t_err, t_after;
    int          t_lat;

    initial begin
        tbl[0] = '{0, 1, 0, 16'h0010, 16'h0000, 2'b00, 16'h0000, 0};
        tbl[1] = '{1, 0, 1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 0};
        tbl[2] = '{0, 1, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 0};
        tbl[3] = '{1, 0, 1, 16'h0010, 16'h1200, 2'b10, 16'h0000, 0};
        tbl[4] = '{0, 1, 0, 16'h0010, 16'h0000, 2'b00, 16'h12EF, 0};
        tbl[5] = '{0, 1, 1, 16'h0040, 16'h00FF, 2'b11, 16'h12EF, 1};
        tbl[6] = '{1, 1, 0, 16'h0240, 16'h0000, 2'b00, 16'h00FF, 0};
        tbl[7] = '{1, 1, 0, 16'h0210, 16'h0000, 2'b00, 16'h12EF, 0};
        tbl[8] = '{0, 0, 1, 16'h0010, 16'hFFFF, 2'b00, 16'h12EF, 0};
        tbl[9] = '{0, 1, 0, 16'h0011, 16'h0000, 2'b00, 16'h12EF, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_a", {15'b0, resp_a}, 16'h0);
        chk("reset_resp_b", {15'b0, resp_b}, 16'h0);
        chk("reset_err_a", {15'b0, err_a}, 16'h0);
        chk("reset_rdata_a", rdata_a, 16'h0);
        chk("reset_rdata_b", rdata_b, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].port, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
                t_rdata, t_err, t_lat, t_after);
            chk($sformatf("vec%0d_latency", i), 16'(t_lat), tbl[i].port ? 16'(LAT_B) : 16'(LAT_A));
            chk($sformatf("vec%0d_rdata", i), t_rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {15'b0, t_err}, {15'b0, tbl[i].exp_err});
            chk($sformatf("vec%0d_resp_one_cycle", i), {15'b0, t_after}, 16'h0);
        end

        // Write/write collision on one word: B at cycle 0 (lat 4), A at cycle 2 (lat 2)
        drive(1, 0, 1, 16'h0020, 16'h5555, 2'b11);
        repeat (2) @(posedge clk);
        #1 drive(0, 0, 1, 16'h0020, 16'hAAAA, 2'b01);
        repeat (3) @(negedge clk);
        chk("ww_resp_a", {15'b0, resp_a}, 16'h1);
        chk("ww_resp_b", {15'b0, resp_b}, 16'h1);
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        drive(1, 0, 0, 16'h0, 16'h0, 2'b00);
        @(posedge clk);
        #1;
        txn(0, 1, 0, 16'h0020, 16'h0, 2'b00, t_rdata, t_err, t_lat, t_after);
        chk("ww_merge", t_rdata, 16'h55AA);

        // Read/write collision: B reads the old value
        drive(1, 1, 0, 16'h0030, 16'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1 drive(0, 0, 1, 16'h0030, 16'h1234, 2'b11);
        repeat (3) @(negedge clk);
        chk("rw_resp_b", {15'b0, resp_b}, 16'h1);
        chk("rw_rdata_b_old", rdata_b, 16'h0000);
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        drive(1, 0, 0, 16'h0, 16'h0, 2'b00);
        @(posedge clk);
        #1;
        txn(1, 1, 0, 16'h0030, 16'h0, 2'b00, t_rdata, t_err, t_lat, t_after);
        chk("rw_new_value", t_rdata, 16'h1234);

        // Abort: B write dropped after 2 request cycles
        drive(1, 0, 1, 16'h0050, 16'h7777, 2'b11);
        repeat (2) @(posedge clk);
        #1 drive(1, 0, 0, 16'h0, 16'h0, 2'b00);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("abort_no_resp_b c%0d", c), {15'b0, resp_b}, 16'h0);
        end
        @(posedge clk);
        #1;
        txn(0, 1, 0, 16'h0050, 16'h0, 2'b00, t_rdata, t_err, t_lat, t_after);
        chk("abort_word_unchanged", t_rdata, 16'h0000);

        // Randomized two-port run from a clean reset
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0;
        begin
            int          lat_of[2];
            bit          act[2], done[2], trd[2], twr[2];
            int          held[2], gap[2];
            logic [15:0] tad[2], twd[2], exp_rd[2];
            logic [1:0]  tmk[2];
            logic        exp_resp[2], exp_err[2];
            lat_of[0] = LAT_A;
            lat_of[1] = LAT_B;
            for (int p = 0; p < 2; p++) begin
                act[p] = 0; held[p] = 0; gap[p] = 0; exp_rd[p] = 16'h0;
                trd[p] = 0; twr[p] = 0; tad[p] = 16'h0; twd[p] = 16'h0; tmk[p] = 2'b00;
            end
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(posedge clk);
                for (int p = 0; p < 2; p++) begin
                    done[p] = 0;
                    exp_resp[p] = 0;
                    exp_err[p] = 0;
                    if (act[p]) begin
                        held[p]++;
                        if (held[p] == lat_of[p]) done[p] = 1;
                    end
                end
                for (int p = 0; p < 2; p++)
                    if (done[p] && trd[p] && !twr[p]) exp_rd[p] = mdl[tad[p][8:1]];
                for (int p = 1; p >= 0; p--)
                    if (done[p] && twr[p])
                        mdl[tad[p][8:1]] = model_write(mdl[tad[p][8:1]], twd[p], tmk[p]);
                for (int p = 0; p < 2; p++) begin
                    if (done[p]) begin
                        exp_resp[p] = 1;
                        exp_err[p] = trd[p] && twr[p];
                    end
                end
                #1;
                for (int p = 0; p < 2; p++) begin
                    if (done[p]) begin
                        drive(p[0], 0, 0, 16'h0, 16'h0, 2'b00);
                        act[p] = 0;
                        gap[p] = int'($urandom_range(0, 2));
                    end else if (!act[p]) begin
                        if (gap[p] == 0) begin
                            int op;
                            op = int'($urandom_range(0, 9));
                            trd[p] = (op <= 3) || (op == 9);
                            twr[p] = (op >= 4);
                            tad[p] = {7'($urandom), 8'($urandom_range(0, 7)), 1'($urandom)};
                            twd[p] = 16'($urandom);
                            tmk[p] = 2'($urandom);
                            drive(p[0], trd[p], twr[p], tad[p], twd[p], tmk[p]);
                            act[p] = 1;
                            held[p] = 0;
                        end else begin
                            gap[p]--;
                        end
                    end
                end
                @(negedge clk);
                chk($sformatf("rand_resp_a c%0d", cyc), {15'b0, resp_a}, {15'b0, exp_resp[0]});
                chk($sformatf("rand_resp_b c%0d", cyc), {15'b0, resp_b}, {15'b0, exp_resp[1]});
                chk($sformatf("rand_err_a c%0d", cyc), {15'b0, err_a}, {15'b0, exp_err[0]});
                chk($sformatf("rand_err_b c%0d", cyc), {15'b0, err_b}, {15'b0, exp_err[1]});
                chk($sformatf("rand_rdata_a c%0d", cyc), rdata_a, exp_rd[0]);
                chk($sformatf("rand_rdata_b c%0d", cyc), rdata_b, exp_rd[1]);
            end
        end
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        drive(1, 0, 0, 16'h0, 16'h0, 2'b00);
        @(posedge clk);
        #1;

        // Reset while port A is in WAIT
        drive(0, 0, 1, 16'h0060, 16'hABCD, 2'b11);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        @(negedge clk);
        chk("midwait_rst_resp_a", {15'b0, resp_a}, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_resp_a c%0d", c), {15'b0, resp_a}, 16'h0);
        end
        chk("post_rst_rdata_a", rdata_a, 16'h0);
        chk("post_rst_rdata_b", rdata_b, 16'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            txn(0, 1, 0, 16'(i * 2), 16'h0, 2'b00, t_rdata, t_err, t_lat, t_after);
            chk($sformatf("post_rst_word%0d", i), t_rdata, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
